// File: rtl/fwrisc_mds_arbiter_if.sv
// Bus between NREQ requesters, the shared mul/div/shift unit and fwrisc_mds_arbiter.
// The arbiter takes the slave modport; requesters and the unit together form the master side.
interface fwrisc_mds_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [4*NREQ-1:0]  req_op;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic [31:0]        mds_in_a;
    logic [31:0]        mds_in_b;
    logic [3:0]         mds_op;
    logic               mds_in_valid;
    logic [31:0]        mds_out;
    logic               mds_out_valid;

    modport master (
        output req_valid, req_a, req_b, req_op, mds_out, mds_out_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mds_in_a, mds_in_b, mds_op, mds_in_valid
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, mds_out, mds_out_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mds_in_a, mds_in_b, mds_op, mds_in_valid
    );
endinterface

// File: rtl/fwrisc_mds_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mul/div/shift unit between NREQ requesters,
// with a watchdog that answers with an error if the unit never returns a result.
module fwrisc_mds_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    fwrisc_mds_arbiter_if.slave     bus,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int          IDW      = $clog2(NREQ);
    localparam logic [31:0] CNT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [31:0]    cnt;
    logic           drain;
    logic           found;
    logic [IDW-1:0] winner;

    // Search starts just after the last grantee, so the most recent winner has lowest priority.
    function automatic logic [IDW:0] pick_next(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW:0]   result;
        logic [IDW-1:0] idx;
        result = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!result[IDW] && valid[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    always_comb begin
        {found, winner} = pick_next(bus.req_valid, ptr);
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            ptr              <= IDW'(NREQ - 1);
            grant_id         <= '0;
            cnt              <= '0;
            drain            <= 1'b0;
            bus.mds_in_a     <= '0;
            bus.mds_in_b     <= '0;
            bus.mds_op       <= '0;
            bus.mds_in_valid <= 1'b0;
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            bus.mds_in_valid <= 1'b0;
            bus.rsp_valid    <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.mds_in_a     <= bus.req_a[32*int'(winner) +: 32];
                        bus.mds_in_b     <= bus.req_b[32*int'(winner) +: 32];
                        bus.mds_op       <= bus.req_op[4*int'(winner) +: 4];
                        ptr              <= winner;
                        grant_id         <= winner;
                        bus.mds_in_valid <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the final watchdog cycle still counts as a normal response.
                    if (bus.mds_out_valid) begin
                        bus.rsp_data            <= bus.mds_out;
                        bus.rsp_err             <= 1'b0;
                        bus.rsp_valid[grant_id] <= 1'b1;
                        drain                   <= 1'b0;
                        state                   <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        bus.rsp_data            <= '0;
                        bus.rsp_err             <= 1'b1;
                        bus.rsp_valid[grant_id] <= 1'b1;
                        drain                   <= 1'b1;
                        state                   <= RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= drain ? DRAIN : IDLE;
                end
                DRAIN: begin
                    // The late result belongs to the timed-out op; swallow it before granting again.
                    if (bus.mds_out_valid) begin
                        drain <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fwrisc_mds_arbiter.sv
// Randomized bench for fwrisc_mds_arbiter: a transaction-level model predicts grants, issue
// pulses and responses from round-robin order and the unit latency chosen for each op.
module tb_fwrisc_mds_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 8;
    localparam int IDW     = $clog2(NREQ);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           busy;
    logic [IDW-1:0] grant_id;

    fwrisc_mds_arbiter_if #(.NREQ(NREQ)) bus ();

    fwrisc_mds_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          pend [NREQ];
    logic [31:0] pa   [NREQ];
    logic [31:0] pb   [NREQ];
    logic [3:0]  pop  [NREQ];
    int          free_at    = 0;
    int          last_grant = NREQ - 1;
    int          issue_cyc  = -1;
    int          rsp_cyc    = -1;
    int          out_cyc    = -1;
    int          rsp_id     = 0;
    logic [31:0] exp_data, exp_a, exp_b;
    logic [3:0]  exp_op;
    logic        exp_err;
    int          force_lat   = -1;
    int          gen_mode    = 0;
    bit          do_reset    = 1'b0;
    bit          force_stray = 1'b0;
    bit          stray_en    = 1'b0;

    function automatic logic [31:0] unitResult(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd3:    return a * b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            default: return a ^ b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, want);
        end
    endtask

    task automatic postRequest(input int i, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pop[i]  = op;
    endtask

    task automatic applyStimulus(input int n);
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rsp;
        bit              free;
        int              w;
        int              j;
        int              lat;
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if (gen_mode == 1 && $urandom_range(0, 3) == 0)
                        postRequest(i, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
                    else if (gen_mode == 2 && i < 2)
                        postRequest(i, $urandom_range(0, 65535), $urandom_range(0, 65535), 4'd3);
                end
                bus.req_valid[i]       = pend[i];
                bus.req_a[32*i +: 32]  = pa[i];
                bus.req_b[32*i +: 32]  = pb[i];
                bus.req_op[4*i +: 4]   = pop[i];
            end
            free = (cyc >= free_at);
            bus.mds_out_valid = (cyc == out_cyc) ||
                                (free && (force_stray || (stray_en && $urandom_range(0, 9) == 0)));
            bus.mds_out = (cyc == out_cyc) ? unitResult(bus.mds_in_a, bus.mds_in_b, bus.mds_op)
                                           : $urandom();
            reset = !do_reset;

            @(negedge clock);
            exp_ready = '0;
            w = -1;
            if (free) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (last_grant + k) % NREQ;
                    if (w < 0 && pend[j]) w = j;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            exp_rsp = '0;
            if (cyc == rsp_cyc) exp_rsp[rsp_id] = 1'b1;

            checkOutput("req_ready", bus.req_ready, exp_ready);
            checkOutput("busy", busy, !free);
            checkOutput("rsp_valid", bus.rsp_valid, exp_rsp);
            checkOutput("mds_in_valid", bus.mds_in_valid, cyc == issue_cyc);
            if (cyc == issue_cyc) begin
                checkOutput("mds_in_a", bus.mds_in_a, exp_a);
                checkOutput("mds_in_b", bus.mds_in_b, exp_b);
                checkOutput("mds_op", bus.mds_op, exp_op);
                checkOutput("grant_id_issue", grant_id, rsp_id);
            end
            if (cyc == rsp_cyc) begin
                checkOutput("rsp_data", bus.rsp_data, exp_data);
                checkOutput("rsp_err", bus.rsp_err, exp_err);
                checkOutput("grant_id_rsp", grant_id, rsp_id);
            end

            if (do_reset) begin
                // The unit still fires its stale result later; only the arbiter forgets the op.
                free_at    = cyc + 1;
                issue_cyc  = -1;
                rsp_cyc    = -1;
                last_grant = NREQ - 1;
            end else if (w >= 0) begin
                if (force_lat > 0)
                    lat = force_lat;
                else if ($urandom_range(0, 3) == 0)
                    lat = $urandom_range(TIMEOUT + 2, TIMEOUT + 6);
                else
                    lat = $urandom_range(1, TIMEOUT);
                rsp_id    = w;
                exp_a     = pa[w];
                exp_b     = pb[w];
                exp_op    = pop[w];
                issue_cyc = cyc + 1;
                out_cyc   = cyc + 1 + lat;
                if (lat <= TIMEOUT) begin
                    rsp_cyc  = cyc + 2 + lat;
                    exp_data = unitResult(pa[w], pb[w], pop[w]);
                    exp_err  = 1'b0;
                    free_at  = cyc + 3 + lat;
                end else begin
                    rsp_cyc  = cyc + 2 + TIMEOUT;
                    exp_data = '0;
                    exp_err  = 1'b1;
                    free_at  = cyc + 2 + lat;
                end
                last_grant = w;
                pend[w]    = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
            pop[i]  = '0;
        end
        bus.req_valid     = '0;
        bus.req_a         = '0;
        bus.req_b         = '0;
        bus.req_op        = '0;
        bus.mds_out       = '0;
        bus.mds_out_valid = 1'b0;
        reset             = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_rsp_valid", bus.rsp_valid, '0);
        checkOutput("reset_rsp_data", bus.rsp_data, '0);
        checkOutput("reset_rsp_err", bus.rsp_err, '0);
        checkOutput("reset_mds_in_a", bus.mds_in_a, '0);
        checkOutput("reset_mds_op", bus.mds_op, '0);
        checkOutput("reset_mds_in_valid", bus.mds_in_valid, '0);
        checkOutput("reset_busy", busy, '0);
        checkOutput("reset_grant_id", grant_id, '0);

        // Single op: 7*6 with unit latency 4.
        postRequest(0, 32'd7, 32'd6, 4'd3);
        force_lat = 4;
        applyStimulus(10);

        // Requesters 0 and 1 held continuously alternate grants.
        force_lat = 3;
        gen_mode  = 2;
        applyStimulus(40);
        gen_mode  = 0;
        applyStimulus(20);

        // Hung unit: error response, then DRAIN blocks requester 1 until the late result.
        postRequest(0, 32'd5, 32'd9, 4'd3);
        force_lat = 20;
        applyStimulus(1);
        force_lat = 3;
        applyStimulus(2);
        postRequest(1, 32'd11, 32'd3, 4'd1);
        applyStimulus(30);

        // Result on the last watchdog cycle is a normal response.
        postRequest(2, 32'd100, 32'd4, 4'd4);
        force_lat = TIMEOUT;
        applyStimulus(14);

        // Reset while waiting on the unit, then the stale result must be ignored.
        postRequest(1, 32'd3, 32'd4, 4'd0);
        force_lat = 20;
        applyStimulus(4);
        do_reset = 1'b1;
        applyStimulus(1);
        do_reset = 1'b0;
        applyStimulus(1);
        checkOutput("post_reset_rsp_data", bus.rsp_data, '0);
        checkOutput("post_reset_rsp_err", bus.rsp_err, '0);
        checkOutput("post_reset_mds_in_a", bus.mds_in_a, '0);
        checkOutput("post_reset_mds_in_b", bus.mds_in_b, '0);
        checkOutput("post_reset_mds_op", bus.mds_op, '0);
        checkOutput("post_reset_grant_id", grant_id, '0);
        applyStimulus(22);
        postRequest(0, 32'd2, 32'd8, 4'd3);
        postRequest(1, 32'd6, 32'd1, 4'd5);
        force_lat = 2;
        applyStimulus(20);

        // Stray unit strobe while idle.
        force_stray = 1'b1;
        applyStimulus(1);
        force_stray = 1'b0;
        applyStimulus(3);

        // Random traffic with random latencies, timeouts and stray strobes.
        force_lat = -1;
        gen_mode  = 1;
        stray_en  = 1'b1;
        applyStimulus(3000);
        gen_mode  = 0;
        stray_en  = 1'b0;
        applyStimulus(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
